// File: rtl/fwd_scoreboard_pkg.sv
// Shared core package for the forwarding/scoreboard block: forwarding-select
// encodings, default parameter values and the address/select width helpers.
package fwd_scoreboard_pkg;

  // Default configuration
  localparam int DEF_NUM_SRC = 2;
  localparam int DEF_NUM_FWD = 2;
  localparam int DEF_NREG    = 32;

  // Forwarding-select encodings: 0 reads the register file, k picks stage k
  localparam int SEL_REGFILE = 0;
  localparam int SEL_MEM     = 1;
  localparam int SEL_WB      = 2;

  // Register address width for a register file of nreg entries
  function automatic int aw_of(input int nreg);
    return $clog2(nreg);
  endfunction

  // Select width able to encode the register file plus num_fwd stages
  function automatic int sw_of(input int num_fwd);
    return $clog2(num_fwd + 1);
  endfunction

endpackage

// File: rtl/fwd_scoreboard_match.sv
// Per-operand forwarding priority match: picks the youngest stage that writes
// the operand's (nonzero) source register, otherwise the register file.
module fwd_match
  import fwd_scoreboard_pkg::*;
#(
  parameter int NUM_FWD = DEF_NUM_FWD,
  parameter int AW      = 5,
  parameter int SW      = 2
) (
  input  logic                  valid,
  input  logic [AW-1:0]         addr,
  input  logic [NUM_FWD-1:0]    fwd_we,
  input  logic [NUM_FWD*AW-1:0] fwd_rd,
  output logic [SW-1:0]         sel
);

  // Scan oldest to youngest so the youngest matching stage overwrites the rest
  always_comb begin
    sel = SW'(SEL_REGFILE);
    for (int k = NUM_FWD; k >= 1; k--) begin
      if (valid && (addr != '0) && fwd_we[k-1] &&
          (fwd_rd[(k-1)*AW +: AW] == addr)) begin
        sel = SW'(k);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand forwarding select and hazard scoreboard for the EX stage.
// Optional stall performance counter enabled by macro FWD_SCOREBOARD_PERF_EN.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int NUM_FWD = DEF_NUM_FWD,
  parameter int NREG    = DEF_NREG,
  localparam int AW     = aw_of(NREG),
  localparam int SW     = sw_of(NUM_FWD)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic [NUM_SRC*AW-1:0] src_addr,
  input  logic [NUM_FWD-1:0]    fwd_we,
  input  logic [NUM_FWD*AW-1:0] fwd_rd,
  input  logic                  ex_load,
  input  logic [AW-1:0]         ex_rd,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  input  logic                  cmpl_valid,
  input  logic [AW-1:0]         cmpl_rd,
  output logic [NUM_SRC*SW-1:0] fwd_sel,
  output logic                  stall,
  output logic [AW:0]           pending_cnt
`ifdef FWD_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  logic [NREG-1:0]    pending_reg;
  logic [NREG-1:0]    pending_next;
  logic [AW:0]        cnt_reg;
  logic [AW:0]        cnt_next;
  logic [NUM_SRC-1:0] load_hit;
  logic [NUM_SRC-1:0] sb_hit;
  logic               waw_hit;
  logic               set_en;
  logic               clear_en;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [AW-1:0] addr;
      logic          live;

      assign addr = src_addr[gi*AW +: AW];
      assign live = src_valid[gi] && (addr != '0);

      // Load result is not available yet for an operand that reads it
      assign load_hit[gi] = live && ex_load && (ex_rd != '0) && (ex_rd == addr);
      // Operand waits on an outstanding long-latency write
      assign sb_hit[gi]   = live && pending_reg[addr];

      fwd_match #(
        .NUM_FWD (NUM_FWD),
        .AW      (AW),
        .SW      (SW)
      ) u_match (
        .valid  (src_valid[gi]),
        .addr   (addr),
        .fwd_we (fwd_we),
        .fwd_rd (fwd_rd),
        .sel    (fwd_sel[gi*SW +: SW])
      );
    end
  endgenerate

  assign waw_hit = iss_valid && pending_reg[iss_rd];
  assign stall   = (|load_hit) || (|sb_hit) || waw_hit;

  // A new long-latency op claims its destination only when it actually issues.
  // A completion racing an issue to the same register keeps the bit set.
  assign set_en   = iss_valid && !stall && (iss_rd != '0);
  assign clear_en = cmpl_valid && (cmpl_rd != '0) &&
                    !(iss_valid && (iss_rd == cmpl_rd));

  // Next pending table: clear first so a simultaneous set dominates
  always_comb begin
    pending_next = pending_reg;
    if (clear_en) pending_next[cmpl_rd] = 1'b0;
    if (set_en)   pending_next[iss_rd]  = 1'b1;
    pending_next[0] = 1'b0;
  end

  // Population count of the next table so the count tracks it edge for edge
  always_comb begin
    cnt_next = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_next = cnt_next + (AW+1)'(pending_next[r]);
    end
  end

  // Pending table and its count, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= '0;
      cnt_reg     <= '0;
    end else begin
      pending_reg <= pending_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign pending_cnt = cnt_reg;

`ifdef FWD_SCOREBOARD_PERF_EN
  logic [31:0] stall_cnt_reg;

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  // No stall performance counter in this build.
`endif

endmodule
